mem_io_responder: RTL and testbench

- Memory-side responder for the CPU's byte-wide memory bus.
- The CPU drives address, write data and the write flag. This block returns read data one cycle later.
- Backs 128 KB of RAM and decodes the I/O window at mem_a[17:16]==2'b11: UART TX FIFO, RX byte source, cycle counter, program stop.
- Instantiated beside cpu in the simulation/FPGA top, replacing the ad-hoc RAM+UART glue.

---
 rtl/mem_io_responder.sv | 179 +++++++++++++++++
 tb/tb_mem_io_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Memory-side responder for the CPU byte bus. Backs 2**ADDR_BITS bytes of
//   RAM and decodes an I/O window at mem_a[17:16] == 2'b11:
//     0x30000 write : push nonzero byte into UART TX FIFO (0x00 ignored)
//     0x30000 read  : received byte (MEM_IO_RX_EN builds only, else 0x00)
//     0x30004 write : raise sticky sim_stop
//     0x30004..7 rd : free-running cycle counter, little-endian; reading
//                     byte 0 captures a snapshot that bytes 1..3 return
//   Read data is registered: valid one cycle after the address.
//
// Optional feature macro: MEM_IO_RX_EN (RX byte source on 0x30000 reads).
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-low reset
//   rdy_in                 CPU accesses act only when high
//   mem_a/mem_dout/mem_wr  CPU address, write data, write flag
//   mem_din                registered read data to CPU
//   io_buffer_full         registered TX FIFO near-full flag
//   tx_data/tx_valid/tx_ready  TX FIFO head towards UART
//   rx_data/rx_valid/rx_ready  RX byte source (rx_ready = pop strobe)
//   tx_overflow, sim_stop  sticky status flags
module mem_io_responder #(
  parameter int ADDR_BITS      = 17,
  parameter int TX_DEPTH       = 8,
  parameter int TX_FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        sim_stop
);

  localparam int IW = $clog2(TX_DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_LVL = PW'(TX_DEPTH);
  localparam logic [PW-1:0] FULL_LVL  = PW'(TX_DEPTH - TX_FULL_MARGIN);

  logic [7:0]           ram [0:(2**ADDR_BITS)-1];
  logic [7:0]           fifo [0:TX_DEPTH-1];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [31:0]          counter;
  logic [31:0]          snapshot;

  logic                 is_io;
  logic [15:0]          io_off;
  logic [ADDR_BITS-1:0] ram_idx;
  logic                 ram_wr;
  logic                 ram_rd;
  logic                 io_rd;
  logic                 push_req;
  logic                 push_ok;
  logic                 drop;
  logic                 pop;
  logic                 stop_wr;
  logic                 snap_take;
  logic                 rx_pop;
  logic [PW-1:0]        count;
  logic [PW-1:0]        next_count;
  logic [7:0]           io_rdata;

  // Bits outside the decoded range (and RX inputs when RX is compiled out).
  logic                 unused_bits;
`ifdef MEM_IO_RX_EN
  assign unused_bits = ^mem_a[31:18];
`else
  assign unused_bits = ^{mem_a[31:18], rx_data, rx_valid};
`endif

  // Head of FIFO is presented combinationally; pointers differ when non-empty.
  assign tx_data  = fifo[rd_ptr[IW-1:0]];
  assign tx_valid = (wr_ptr != rd_ptr);

  // Address decode, FIFO push/pop qualification and I/O read mux.
  always_comb begin
    is_io     = (mem_a[17:16] == 2'b11);
    io_off    = mem_a[15:0];
    ram_idx   = mem_a[ADDR_BITS-1:0];
    ram_wr    = rdy_in & ~is_io & mem_wr;
    ram_rd    = rdy_in & ~is_io & ~mem_wr;
    io_rd     = rdy_in & is_io & ~mem_wr;
    push_req  = rdy_in & is_io & mem_wr & (io_off == 16'h0000) & (mem_dout != 8'h00);
    stop_wr   = rdy_in & is_io & mem_wr & (io_off == 16'h0004);
    snap_take = io_rd & (io_off == 16'h0004);
    count     = wr_ptr - rd_ptr;
    pop       = tx_valid & tx_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
    push_ok   = push_req & ((count != DEPTH_LVL) | pop);
    drop      = push_req & (count == DEPTH_LVL) & ~pop;
    next_count = count + PW'(push_ok) - PW'(pop);
`ifdef MEM_IO_RX_EN
    rx_pop    = io_rd & (io_off == 16'h0000) & rx_valid;
`else
    rx_pop    = 1'b0;
`endif
    io_rdata  = 8'h00;
    if (io_off == 16'h0000) begin
`ifdef MEM_IO_RX_EN
      io_rdata = rx_valid ? rx_data : 8'h00;
`else
      io_rdata = 8'h00;
`endif
    end else if (io_off[15:2] == 14'd1) begin
      // Byte 0 shows the live counter (the snapshot is taken on this edge).
      case (io_off[1:0])
        2'd0:    io_rdata = counter[7:0];
        2'd1:    io_rdata = snapshot[15:8];
        2'd2:    io_rdata = snapshot[23:16];
        2'd3:    io_rdata = snapshot[31:24];
        default: io_rdata = 8'h00;
      endcase
    end else begin
      io_rdata = 8'h00;
    end
  end

  // RAM and FIFO storage: contents are deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (ram_wr) begin
      ram[ram_idx] <= mem_dout;
    end
    if (push_ok) begin
      fifo[wr_ptr[IW-1:0]] <= mem_dout;
    end
  end

  // Control state, read data register, counter and sticky flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din        <= 8'h00;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      io_buffer_full <= 1'b0;
      rx_ready       <= 1'b0;
      tx_overflow    <= 1'b0;
      sim_stop       <= 1'b0;
      counter        <= 32'd0;
      snapshot       <= 32'd0;
    end else begin
      counter  <= counter + 32'd1;
      rx_ready <= rx_pop;
      if (ram_rd) begin
        mem_din <= ram[ram_idx];
      end else if (io_rd) begin
        mem_din <= io_rdata;
      end
      if (snap_take) begin
        snapshot <= counter;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Early warning leaves room for stores already in flight in the CPU.
      io_buffer_full <= (next_count >= FULL_LVL);
      if (drop) begin
        tx_overflow <= 1'b1;
      end
      if (stop_wr) begin
        sim_stop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = 32'd0;
  logic [7:0]  mem_dout = 8'd0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        tx_overflow;
  logic        sim_stop;

  int n_vec  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_overflow(tx_overflow), .sim_stop(sim_stop)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: byte array RAM, queue FIFO, integer cycle counter.
  logic [7:0]  ram_m [0:131071];
  bit          ram_known [0:131071];
  logic [7:0]  q [$];
  logic [31:0] counter_m = 32'd0;
  logic [31:0] snap_m = 32'd0;
  logic [7:0]  exp_din = 8'd0;
  bit          din_known = 1'b1;
  bit          exp_rxr = 1'b0;
  bit          exp_ovf = 1'b0;
  bit          exp_stop = 1'b0;
  bit          exp_afull = 1'b0;

  always @(posedge clk_in or negedge rst_in) begin : model
    logic [17:0] a;
    bit pop, full_before, push;
    if (!rst_in) begin
      q.delete();
      counter_m = 32'd0; snap_m = 32'd0; exp_din = 8'd0; din_known = 1'b1;
      exp_rxr = 1'b0; exp_ovf = 1'b0; exp_stop = 1'b0; exp_afull = 1'b0;
    end else begin
      a = mem_a[17:0];
      pop = (q.size() > 0) && tx_ready;
      full_before = (q.size() == 8);
      push = 1'b0;
      exp_rxr = 1'b0;
      if (rdy_in) begin
        if (a[17:16] != 2'b11) begin
          if (mem_wr) begin
            ram_m[a[16:0]] = mem_dout;
            ram_known[a[16:0]] = 1'b1;
          end else begin
            exp_din = ram_m[a[16:0]];
            din_known = ram_known[a[16:0]];
          end
        end else if (mem_wr) begin
          if (a[15:0] == 16'h0000 && mem_dout != 8'h00) push = 1'b1;
          if (a[15:0] == 16'h0004) exp_stop = 1'b1;
        end else begin
          din_known = 1'b1;
          if (a[15:0] == 16'h0000) begin
`ifdef MEM_IO_RX_EN
            exp_din = rx_valid ? rx_data : 8'h00;
            exp_rxr = rx_valid;
`else
            exp_din = 8'h00;
`endif
          end else if (a[15:0] >= 16'h0004 && a[15:0] <= 16'h0007) begin
            if (a[1:0] == 2'd0) begin
              snap_m = counter_m;
              exp_din = counter_m[7:0];
            end else begin
              exp_din = 8'(snap_m >> (8 * a[1:0]));
            end
          end else begin
            exp_din = 8'h00;
          end
        end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (full_before && !pop) exp_ovf = 1'b1;
        else q.push_back(mem_dout);
      end
      exp_afull = (q.size() >= 6);
      counter_m = counter_m + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT against the model, away from the clock edge.
  always @(posedge clk_in) begin
    #2;
    if (check_en) begin
      if (din_known) chk("mem_din", {24'd0, mem_din}, {24'd0, exp_din});
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, q[0]});
      chk("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, exp_afull});
      chk("tx_overflow", {31'd0, tx_overflow}, {31'd0, exp_ovf});
      chk("sim_stop", {31'd0, sim_stop}, {31'd0, exp_stop});
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, exp_rxr});
    end
  end

  task automatic cyc(input logic rdy, input logic [31:0] a, input logic [7:0] d, input logic wr);
    @(negedge clk_in);
    rdy_in = rdy; mem_a = a; mem_dout = d; mem_wr = wr;
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 8'd0, 1'b0);
  endtask

  task automatic at_edge();
    @(posedge clk_in);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_din"}, {24'd0, mem_din}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_io_full"}, {31'd0, io_buffer_full}, 32'd0);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, tx_overflow}, 32'd0);
    chk({tag, "_sim_stop"}, {31'd0, sim_stop}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    #1 rst_in = 1'b0;
    #2 chk_reset_outputs("por");
    @(negedge clk_in);
    rst_in = 1'b1;
    check_en = 1'b1;

    // RAM write then read; then alias 0x20010 onto 0x00010.
    cyc(1'b1, 32'h0000_0010, 8'hA5, 1'b1);
    cyc(1'b1, 32'h0000_0010, 8'h00, 1'b0);
    at_edge(); chk("ram_rd_a5", {24'd0, mem_din}, 32'h0000_00A5);
    cyc(1'b1, 32'h0002_0010, 8'h5A, 1'b1);
    cyc(1'b1, 32'h0000_0010, 8'h00, 1'b0);
    at_edge(); chk("ram_alias_5a", {24'd0, mem_din}, 32'h0000_005A);
    idle();

    // "Hi\0!" into TX with UART stalled, then drain.
    cyc(1'b1, 32'h0003_0000, 8'h48, 1'b1);
    cyc(1'b1, 32'h0003_0000, 8'h69, 1'b1);
    cyc(1'b1, 32'h0003_0000, 8'h00, 1'b1);
    cyc(1'b1, 32'h0003_0000, 8'h21, 1'b1);
    idle();
    at_edge();
    chk("hi_head", {24'd0, tx_data}, 32'h48);
    chk("hi_valid", {31'd0, tx_valid}, 32'd1);
    chk("hi_notfull", {31'd0, io_buffer_full}, 32'd0);
    @(negedge clk_in); tx_ready = 1'b1;
    at_edge(); chk("hi_pop1", {24'd0, tx_data}, 32'h69);
    at_edge(); chk("hi_pop2", {24'd0, tx_data}, 32'h21);
    at_edge(); chk("hi_empty", {31'd0, tx_valid}, 32'd0);
    @(negedge clk_in); tx_ready = 1'b0;

    // Fill to full, then overflow, then push-with-pop at full.
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 32'h0003_0000, 8'(i), 1'b1);
      at_edge();
      if (i == 5) chk("afull_5", {31'd0, io_buffer_full}, 32'd0);
      if (i == 6) chk("afull_6", {31'd0, io_buffer_full}, 32'd1);
      if (i == 8) chk("ovf_8", {31'd0, tx_overflow}, 32'd0);
      if (i == 9) chk("ovf_9", {31'd0, tx_overflow}, 32'd1);
    end
    chk("full_head", {24'd0, tx_data}, 32'h01);
    cyc(1'b1, 32'h0003_0000, 8'h0A, 1'b1);
    tx_ready = 1'b1;
    at_edge();
    chk("full_pushpop_head", {24'd0, tx_data}, 32'h02);
    chk("full_pushpop_afull", {31'd0, io_buffer_full}, 32'd1);
    idle();
    repeat (10) @(negedge clk_in);
    chk("drained", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Cycle counter snapshot 100 cycles after reset.
    @(negedge clk_in); rst_in = 1'b0;
    @(negedge clk_in); rst_in = 1'b1;
    repeat (99) @(negedge clk_in);
    cyc(1'b1, 32'h0003_0004, 8'h00, 1'b0); at_edge();
    chk("cnt_b0", {24'd0, mem_din}, 32'h64);
    cyc(1'b1, 32'h0003_0005, 8'h00, 1'b0); at_edge();
    chk("cnt_b1", {24'd0, mem_din}, 32'h00);
    cyc(1'b1, 32'h0003_0006, 8'h00, 1'b0); at_edge();
    chk("cnt_b2", {24'd0, mem_din}, 32'h00);
    cyc(1'b1, 32'h0003_0007, 8'h00, 1'b0); at_edge();
    chk("cnt_b3", {24'd0, mem_din}, 32'h00);
    idle();
    // Snapshot across a carry: byte 0 at 0x2FF, byte 1 must still say 0x02.
    guard = 0;
    while (counter_m != 32'h0000_02FE && guard < 2000) begin
      @(negedge clk_in);
      guard++;
    end
    if (guard >= 2000) begin
      n_vec++; n_fail++;
      $display("FAIL cnt_wait: counter %0h never reached 2fe", counter_m);
    end
    cyc(1'b1, 32'h0003_0004, 8'h00, 1'b0); at_edge();
    chk("snap_b0", {24'd0, mem_din}, 32'hFF);
    cyc(1'b1, 32'h0003_0005, 8'h00, 1'b0); at_edge();
    chk("snap_b1", {24'd0, mem_din}, 32'h02);

    // rdy_in low: no RAM write, no push, mem_din held.
    cyc(1'b0, 32'h0000_0010, 8'hEE, 1'b1);
    cyc(1'b0, 32'h0003_0000, 8'h77, 1'b1);
    at_edge();
    chk("rdy0_hold", {24'd0, mem_din}, 32'h02);
    chk("rdy0_nopush", {31'd0, tx_valid}, 32'd0);
    cyc(1'b1, 32'h0000_0010, 8'h00, 1'b0); at_edge();
    chk("rdy0_ram", {24'd0, mem_din}, 32'h5A);

    // RX read, then unmapped IO.
    rx_data = 8'h3C; rx_valid = 1'b1;
    cyc(1'b1, 32'h0003_0000, 8'h00, 1'b0); at_edge();
`ifdef MEM_IO_RX_EN
    chk("rx_data", {24'd0, mem_din}, 32'h3C);
    chk("rx_pulse", {31'd0, rx_ready}, 32'd1);
`else
    chk("rx_data", {24'd0, mem_din}, 32'h00);
    chk("rx_pulse", {31'd0, rx_ready}, 32'd0);
`endif
    idle(); at_edge();
    chk("rx_pulse_end", {31'd0, rx_ready}, 32'd0);
    rx_valid = 1'b0;
    cyc(1'b1, 32'h0003_0008, 8'h55, 1'b1);
    cyc(1'b1, 32'h0003_0010, 8'h00, 1'b0); at_edge();
    chk("io_other", {24'd0, mem_din}, 32'h00);

    // sim_stop, then async reset in the middle of a drain.
    cyc(1'b1, 32'h0003_0004, 8'h99, 1'b1); at_edge();
    chk("sim_stop", {31'd0, sim_stop}, 32'd1);
    chk("stop_nopush", {31'd0, tx_valid}, 32'd0);
    cyc(1'b1, 32'h0003_0000, 8'h41, 1'b1);
    cyc(1'b1, 32'h0003_0000, 8'h42, 1'b1);
    cyc(1'b1, 32'h0003_0000, 8'h43, 1'b1);
    cyc(1'b1, 32'h0000_0010, 8'h00, 1'b0);
    idle();
    tx_ready = 1'b1;
    at_edge();
    chk("drain_mid", {24'd0, tx_data}, 32'h42);
    #1 rst_in = 1'b0;
    #1 chk_reset_outputs("async");
    @(negedge clk_in);
    rst_in = 1'b1; tx_ready = 1'b0;
    repeat (3) @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
